// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file exposed as a flat bus.
// Latency: pins -> filtered levels 2+FILT clk; SDA changes HOLD clk after a detected SCL fall.
// Backpressure: none; never stretches SCL, so the external master sets the pace.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NREGS    = 16,
  parameter int         FILT     = 3,
  parameter int         HOLD     = 4,
  localparam int        IW       = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl_i,
  output logic               scl_oe,
  output logic               scl_o,
  input  logic               sda_i,
  output logic               sda_oe,
  output logic               sda_o,
  output logic [NREGS*8-1:0] regs,
  output logic               wr_stb,
  output logic [IW-1:0]      wr_idx,
  output logic               busy
);

  localparam int FW = $clog2(FILT + 1);
  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_REG, S_WDATA, S_RDATA, S_MACK, S_ACK, S_IGNORE
  } state_t;

  logic [1:0]    scl_sync_q, sda_sync_q;
  logic [FW-1:0] scl_cnt_q, sda_cnt_q;
  logic          scl_f_q, sda_f_q, scl_p_q, sda_p_q;
  logic          scl_rise, scl_fall, start_det, stop_det;

  state_t        state_q, state_d, nxt_q, nxt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          oe_q, oe_d, pend_q, pend_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          wr_en;
  logic [7:0]    rx_byte;
  logic [7:0]    regs_q [NREGS];

  // two-flop synchronizers; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

  // glitch filter: a new level is taken after FILT consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FW'(FILT - 1)) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 1'b1;
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FW'(FILT - 1)) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 1'b1;
      end
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign rx_byte   = {sh_q[6:0], sda_f_q};

  // protocol FSM: next state, pointer, and the delayed SDA drive value
  always_comb begin
    state_d  = state_q;
    nxt_d    = nxt_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    ptr_d    = ptr_q;
    oe_d     = oe_q;
    pend_d   = pend_q;
    hcnt_d   = hcnt_q;
    busy_d   = busy_q;
    wr_stb_d = 1'b0;
    wr_idx_d = wr_idx_q;
    wr_en    = 1'b0;

    // SDA only moves HOLD cycles after the SCL fall that scheduled it
    if (hcnt_q != '0) begin
      hcnt_d = hcnt_q - 1'b1;
      if (hcnt_q == HW'(1)) oe_d = pend_q;
    end

    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      hcnt_d  = '0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
      hcnt_d   = '0;
    end else begin
      case (state_q)
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise) begin
            sh_d     = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = '0;
              if (state_q == S_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy_d  = 1'b1;
                  state_d = S_ACK;
                  if (rx_byte[0]) begin
                    nxt_d = S_RDATA;
                    sh_d  = regs_q[ptr_q];
                  end else begin
                    nxt_d = S_REG;
                  end
                end else begin
                  busy_d  = 1'b0;
                  state_d = S_IGNORE;
                end
              end else if (state_q == S_REG) begin
                ptr_d   = rx_byte[IW-1:0];
                state_d = S_ACK;
                nxt_d   = S_WDATA;
              end else begin
                wr_en    = 1'b1;
                wr_stb_d = 1'b1;
                wr_idx_d = ptr_q;
                ptr_d    = ptr_q + 1'b1;
                state_d  = S_ACK;
                nxt_d    = S_WDATA;
              end
            end
          end else if (scl_fall) begin
            // release after an ACK we gave on the previous 9th clock
            pend_d = 1'b0;
            hcnt_d = HW'(HOLD);
          end
        end
        S_ACK: begin
          if (scl_fall) begin
            pend_d = 1'b1;
            hcnt_d = HW'(HOLD);
          end else if (scl_rise) begin
            state_d  = nxt_q;
            bitcnt_d = '0;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            hcnt_d = HW'(HOLD);
            if (bitcnt_q == 4'd8) begin
              pend_d  = 1'b0;
              ptr_d   = ptr_q + 1'b1;
              state_d = S_MACK;
            end else begin
              pend_d = ~sh_q[3'd7 - bitcnt_q[2:0]];
            end
          end
        end
        S_MACK: begin
          if (scl_rise) begin
            if (!sda_f_q) begin
              sh_d     = regs_q[ptr_q];
              bitcnt_d = '0;
              state_d  = S_RDATA;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        default: begin
          // IDLE / IGNORE: hold until START or STOP
        end
      endcase
    end
  end

  // FSM and datapath state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      nxt_q    <= S_IDLE;
      bitcnt_q <= '0;
      sh_q     <= '0;
      ptr_q    <= '0;
      oe_q     <= 1'b0;
      pend_q   <= 1'b0;
      hcnt_q   <= '0;
      busy_q   <= 1'b0;
      wr_stb_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      nxt_q    <= nxt_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      ptr_q    <= ptr_d;
      oe_q     <= oe_d;
      pend_q   <= pend_d;
      hcnt_q   <= hcnt_d;
      busy_q   <= busy_d;
      wr_stb_q <= wr_stb_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  // register file: written on the 8th rising edge of a completed data byte
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else if (wr_en) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs[8*g +: 8] = regs_q[g];
  end

  assign scl_oe = 1'b0;
  assign scl_o  = 1'b0;
  assign sda_o  = 1'b0;
  assign sda_oe = oe_q;
  assign busy   = busy_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, transaction-level register model,
// scoreboard queues drained by an independent monitor.
module tb_i2c_target_regs;
  localparam int NR = 16;
  localparam int Q  = 12;  // quarter SCL period in clk cycles

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [3:0] idx; logic [7:0] dat;} wr_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           scl_m = 1'b1, sda_m = 1'b1;
  logic           scl_oe, scl_o, sda_oe, sda_o, wr_stb, busy;
  logic [NR*8-1:0] regs;
  logic [3:0]     wr_idx;
  logic           scl_bus, sda_bus;

  assign scl_bus = scl_m & ~scl_oe;
  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl_bus), .scl_oe(scl_oe), .scl_o(scl_o),
    .sda_i(sda_bus), .sda_oe(sda_oe), .sda_o(sda_o), .regs(regs),
    .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] mregs [NR];
  int         mptr = 0;

  // scoreboard queues
  wr_t        exp_wr[$];
  bit         exp_ack[$], got_ack[$];
  logic [7:0] exp_rd[$], got_rd[$];

  bit oe_seen = 0, busy_seen = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] img();
    logic [127:0] r;
    for (int k = 0; k < NR; k++) r[8*k +: 8] = mregs[k];
    return r;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- bit-level master ----------------
  task automatic i2c_start();
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b1; clks(2*Q);
  endtask

  task automatic send_bit(input logic b, input bit glitch, output logic got);
    sda_m = b; clks(Q);
    scl_m = 1'b1;
    if (glitch) begin
      clks(Q/2); sda_m = 1'b0; clks(1); sda_m = b; clks(Q - Q/2 - 1);
    end else begin
      clks(Q);
    end
    got = sda_bus; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, input int gbit);
    logic x;
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == gbit), x);
    send_bit(1'b1, 1'b0, x);
    got_ack.push_back(!x);
  endtask

  task automatic rbyte(input bit mack);
    logic x;
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 1'b0, x);
      v = {v[6:0], x};
    end
    got_rd.push_back(v);
    send_bit(!mack, 1'b0, x);
  endtask

  // ---------------- transactions + model ----------------
  task automatic wr_txn(input logic [7:0] ab, input bq_t d, input int gbyte);
    bit m;
    wr_t e;
    m = (ab[7:1] == 7'h42) && !ab[0];
    exp_ack.push_back(ab[7:1] == 7'h42);
    for (int k = 0; k < d.size(); k++) begin
      exp_ack.push_back(m);
      if (m) begin
        if (k == 0) mptr = d[k] % NR;
        else begin
          mregs[mptr] = d[k];
          e.idx = 4'(mptr); e.dat = d[k];
          exp_wr.push_back(e);
          mptr = (mptr + 1) % NR;
        end
      end
    end
    i2c_start();
    wbyte(ab, -1);
    for (int k = 0; k < d.size(); k++) wbyte(d[k], (k == gbyte) ? 3 : -1);
    i2c_stop();
  endtask

  // p < 0: read from the current pointer; otherwise set it first, then Sr
  task automatic rd_txn(input int p, input int n);
    if (p >= 0) begin
      exp_ack.push_back(1); exp_ack.push_back(1);
      mptr = p % NR;
    end
    exp_ack.push_back(1);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(mregs[mptr]);
      mptr = (mptr + 1) % NR;
    end
    i2c_start();
    if (p >= 0) begin
      wbyte(8'h84, -1);
      wbyte(8'(p), -1);
      i2c_start();
    end
    wbyte(8'h85, -1);
    for (int i = 0; i < n; i++) rbyte(i != n - 1);
    chk("sda_released_after_nack", sda_oe, 0);
    chk("busy_before_stop", busy, 1);
    i2c_stop();
    chk("busy_after_stop", busy, 0);
  endtask

  task automatic drain(input string nm);
    clks(4);
    chk(nm, exp_wr.size() + exp_ack.size() + exp_rd.size() + got_ack.size() + got_rd.size(), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    wr_t e;
    bit a;
    logic [7:0] r;
    forever begin
      @(negedge clk);
      if (wr_stb) begin
        chk("wr_stb_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_idx", wr_idx, e.idx);
          chk("wr_dat", regs[8*int'(e.idx) +: 8], e.dat);
        end
      end
      while (got_ack.size() != 0) begin
        a = got_ack.pop_front();
        chk("ack_expected", exp_ack.size() != 0, 1);
        if (exp_ack.size() != 0) chk("ack", a, exp_ack.pop_front());
      end
      while (got_rd.size() != 0) begin
        r = got_rd.pop_front();
        chk("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) chk("rd_data", r, exp_rd.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1;
    if (busy) busy_seen = 1;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bq_t d;
    for (int k = 0; k < NR; k++) mregs[k] = '0;
    clks(6);
    rst = 1'b0;
    clks(2);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_regs", regs, '0);

    // single write to regs[3]
    d = {}; d.push_back(8'h03); d.push_back(8'hA5);
    wr_txn(8'h84, d, -1);
    chk("img_single_write", regs, img());
    drain("drain_single_write");

    // burst write wrapping 14,15,0
    d = {}; d.push_back(8'h0E); d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
    wr_txn(8'h84, d, -1);
    chk("img_burst_wrap", regs, img());
    drain("drain_burst_wrap");

    // preload 5,6 then read them back through a repeated START
    d = {}; d.push_back(8'h05); d.push_back(8'h5A); d.push_back(8'hC3);
    wr_txn(8'h84, d, -1);
    rd_txn(5, 2);
    drain("drain_read_sr");

    // address mismatch: never ACKs, never busy, nothing written
    oe_seen = 0; busy_seen = 0;
    d = {}; d.push_back(8'h00); d.push_back(8'hFF);
    wr_txn(8'h86, d, -1);
    chk("mismatch_no_oe", oe_seen, 0);
    chk("mismatch_no_busy", busy_seen, 0);
    chk("img_mismatch", regs, img());
    drain("drain_mismatch");

    // STOP after 4 data bits: byte dropped, pointer stays 2
    begin
      logic x;
      exp_ack.push_back(1); exp_ack.push_back(1);
      mptr = 2;
      i2c_start();
      wbyte(8'h84, -1);
      wbyte(8'h02, -1);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, x);
      i2c_stop();
    end
    chk("img_cut_byte", regs, img());
    drain("drain_cut_byte");
    rd_txn(-1, 1);
    d = {}; d.push_back(8'h02); d.push_back(8'h77);
    wr_txn(8'h84, d, -1);
    chk("img_after_cut", regs, img());
    drain("drain_after_cut");

    // 1-cycle SDA low pulse during SCL high must not act as START
    d = {}; d.push_back(8'h07); d.push_back(8'h3C);
    wr_txn(8'h84, d, 1);
    chk("img_glitch", regs, img());
    drain("drain_glitch");

    // randomized mix of burst writes and pointer+reads
    for (int r = 0; r < 6; r++) begin
      int p, n;
      p = $urandom_range(0, 255);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = {}; d.push_back(8'(p));
        for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
        wr_txn(8'h84, d, -1);
      end else begin
        rd_txn(p, n);
      end
      chk("img_random", regs, img());
      drain("drain_random");
    end

    // reset while the target drives a 0 read bit
    d = {}; d.push_back(8'h09); d.push_back(8'h12);
    wr_txn(8'h84, d, -1);
    drain("drain_preload_rst");
    exp_ack.push_back(1); exp_ack.push_back(1); exp_ack.push_back(1);
    i2c_start();
    wbyte(8'h84, -1);
    wbyte(8'h09, -1);
    i2c_start();
    wbyte(8'h85, -1);
    chk("target_drives_0", sda_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_releases_sda", sda_oe, 0);
    chk("rst_clears_regs", regs, '0);
    scl_m = 1'b1; clks(2);
    sda_m = 1'b1; clks(10);
    rst = 1'b0;
    for (int k = 0; k < NR; k++) mregs[k] = '0;
    mptr = 0;
    clks(4);
    chk("rst_busy_low", busy, 0);
    drain("drain_after_rst");
    d = {}; d.push_back(8'h0F); d.push_back(8'h9C); d.push_back(8'h4E);
    wr_txn(8'h84, d, -1);
    chk("img_final", regs, img());
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
